// File: rtl/dram_read_cache.sv
// dram_read_cache
// Direct-mapped, write-through, one-word-per-line cache between the core's
// DRAM port and the SDRAM controller. Read hits are served locally. Read
// misses and all writes go to the controller. Both sides use a level request
// with a one-cycle completion pulse.
module dram_read_cache #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      up_addr,
  input  logic             up_req_read,
  input  logic             up_req_write,
  input  logic [31:0]      up_data_in,
  output logic [31:0]      up_data_out,
  output logic             up_data_valid,
  output logic             up_write_complete,
  output logic [23:0]      dn_addr,
  output logic             dn_req_read,
  output logic             dn_req_write,
  output logic [31:0]      dn_data_out,
  input  logic [31:0]      dn_data_in,
  input  logic             dn_data_valid,
  input  logic             dn_write_complete,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LINES = 2 ** IDX_W;
  localparam int TAG_W = 24 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RESP,
    S_MEM_RD,
    S_MEM_WR,
    S_RELEASE
  } state_e;

  // Control and datapath registers
  state_e           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             op_wr_q, op_wr_d;
  logic [31:0]      line_q, line_d;
  logic             flush_pend_q, flush_pend_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  // Registered outputs
  logic [31:0]      up_data_out_q, up_data_out_d;
  logic             up_data_valid_q, up_data_valid_d;
  logic             up_write_complete_q, up_write_complete_d;
  logic [23:0]      dn_addr_q, dn_addr_d;
  logic             dn_req_read_q, dn_req_read_d;
  logic             dn_req_write_q, dn_req_write_d;
  logic [31:0]      dn_data_out_q, dn_data_out_d;

  // Tag/data storage with a registered read port
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_rd_q;
  logic [31:0]      data_rd_q;
  logic             mem_we;
  logic             mem_re;
  logic [31:0]      mem_wdata;

  // Address fields and lookup result
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             lookup_hit;
  logic             enter_release;

  assign req_idx    = up_addr[IDX_W-1:0];
  assign cur_idx    = addr_q[IDX_W-1:0];
  assign cur_tag    = addr_q[23:IDX_W];
  assign lookup_hit = valid_q[cur_idx] && (tag_rd_q == cur_tag);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, datapath and output computation for the request FSM
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d             = state_q;
    addr_d              = addr_q;
    wdata_d             = wdata_q;
    op_wr_d             = op_wr_q;
    line_d              = line_q;
    flush_pend_d        = flush_pend_q;
    valid_d             = valid_q;
    hit_d               = hit_q;
    miss_d              = miss_q;
    up_data_out_d       = up_data_out_q;
    up_data_valid_d     = 1'b0;
    up_write_complete_d = 1'b0;
    dn_addr_d           = dn_addr_q;
    dn_req_read_d       = dn_req_read_q;
    dn_req_write_d      = dn_req_write_q;
    dn_data_out_d       = dn_data_out_q;
    mem_we              = 1'b0;
    mem_re              = 1'b0;
    mem_wdata           = wdata_q;
    enter_release       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A flush here clears before the lookup, so an op accepted on the
        // same edge sees its line invalid.
        if (flush) valid_d = '0;
        if (up_req_read || up_req_write) begin
          addr_d  = up_addr;
          wdata_d = up_data_in;
          op_wr_d = up_req_write;
          mem_re  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (op_wr_q) begin
          dn_req_write_d = 1'b1;
          dn_addr_d      = addr_q;
          dn_data_out_d  = wdata_q;
          state_d        = S_MEM_WR;
        end else if (lookup_hit) begin
          line_d  = data_rd_q;
          hit_d   = sat_inc(hit_q);
          state_d = S_RESP;
        end else begin
          miss_d        = sat_inc(miss_q);
          dn_req_read_d = 1'b1;
          dn_addr_d     = addr_q;
          state_d       = S_MEM_RD;
        end
      end

      S_RESP: begin
        up_data_out_d   = line_q;
        up_data_valid_d = 1'b1;
        enter_release   = 1'b1;
        state_d         = S_RELEASE;
      end

      S_MEM_RD: begin
        if (dn_data_valid) begin
          mem_we           = 1'b1;
          mem_wdata        = dn_data_in;
          valid_d[cur_idx] = 1'b1;
          up_data_out_d    = dn_data_in;
          up_data_valid_d  = 1'b1;
          dn_req_read_d    = 1'b0;
          dn_addr_d        = '0;
          enter_release    = 1'b1;
          state_d          = S_RELEASE;
        end
      end

      S_MEM_WR: begin
        // The line is only touched once the controller has committed the
        // write, so a concurrent reader can never see data SDRAM lacks.
        if (dn_write_complete) begin
          mem_we              = 1'b1;
          mem_wdata           = wdata_q;
          valid_d[cur_idx]    = 1'b1;
          up_write_complete_d = 1'b1;
          dn_req_write_d      = 1'b0;
          dn_addr_d           = '0;
          dn_data_out_d       = '0;
          enter_release       = 1'b1;
          state_d             = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (flush) valid_d = '0;
        if (!up_req_read && !up_req_write) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A flush seen while busy is deferred until the line update on entry to
    // RELEASE, then wipes every line including the one just written.
    if (state_q != S_IDLE && state_q != S_RELEASE) begin
      if (enter_release) begin
        if (flush || flush_pend_q) valid_d = '0;
        flush_pend_d = 1'b0;
      end else if (flush) begin
        flush_pend_d = 1'b1;
      end
    end

    // The controller shares rst, so a fill landing on a reset edge is dropped.
    if (rst) mem_we = 1'b0;
  end

  // State, control, valid bits, counters and outputs; rst clears all of them
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_IDLE;
      addr_q              <= '0;
      wdata_q             <= '0;
      op_wr_q             <= 1'b0;
      line_q              <= '0;
      flush_pend_q        <= 1'b0;
      valid_q             <= '0;
      hit_q               <= '0;
      miss_q              <= '0;
      up_data_out_q       <= '0;
      up_data_valid_q     <= 1'b0;
      up_write_complete_q <= 1'b0;
      dn_addr_q           <= '0;
      dn_req_read_q       <= 1'b0;
      dn_req_write_q      <= 1'b0;
      dn_data_out_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge value of the others.
      state_q             <= state_d;
      addr_q              <= addr_d;
      wdata_q             <= wdata_d;
      op_wr_q             <= op_wr_d;
      line_q              <= line_d;
      flush_pend_q        <= flush_pend_d;
      valid_q             <= valid_d;
      hit_q               <= hit_d;
      miss_q              <= miss_d;
      up_data_out_q       <= up_data_out_d;
      up_data_valid_q     <= up_data_valid_d;
      up_write_complete_q <= up_write_complete_d;
      dn_addr_q           <= dn_addr_d;
      dn_req_read_q       <= dn_req_read_d;
      dn_req_write_q      <= dn_req_write_d;
      dn_data_out_q       <= dn_data_out_d;
    end
  end

  // Tag/data arrays: synchronous write on line update, registered read on accept
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset; valid_q gates every use, and staying reset-free lets them map to block RAM.
    if (mem_we) begin
      tag_mem[cur_idx]  <= cur_tag;
      data_mem[cur_idx] <= mem_wdata;
    end
    if (mem_re) begin
      tag_rd_q  <= tag_mem[req_idx];
      data_rd_q <= data_mem[req_idx];
    end
  end

  assign up_data_out       = up_data_out_q;
  assign up_data_valid     = up_data_valid_q;
  assign up_write_complete = up_write_complete_q;
  assign dn_addr           = dn_addr_q;
  assign dn_req_read       = dn_req_read_q;
  assign dn_req_write      = dn_req_write_q;
  assign dn_data_out       = dn_data_out_q;
  assign hit_count         = hit_q;
  assign miss_count        = miss_q;

endmodule
